// File: rtl/sc_ctrl_pkg.sv
// Shared types, default sizing and the comparator code generator for the
// stochastic-computing evaluation sequencer.
package sc_ctrl_pkg;

   // Sequencer phases: waiting for a job, streaming, holding a result
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_e;

   // Default stream sizing; modules with their own STREAM_LOG2 derive
   // matching local values from it
   localparam int DEF_STREAM_LOG2 = 4;
   localparam int STREAM_LEN      = 2 ** DEF_STREAM_LOG2;
   localparam int CNT_W           = DEF_STREAM_LOG2 + 1;

   // Comparator code: the low prec bits of t are bit-reversed, so that
   // consecutive cycles spread evenly over the value range, then rotated
   // left by rot so that different variables see decorrelated sequences
   function automatic logic [31:0] rngCode(input logic [31:0] t,
                                           input int prec,
                                           input int rot);
      logic [31:0] revBits;
      logic [31:0] result;
      int          rotMod;
      revBits = '0;
      result  = '0;
      rotMod  = (prec > 0) ? (rot % prec) : 0;
      for (int j = 0; j < 32; j++) begin
         if (j < prec) begin
            revBits[5'(j)] = t[5'(prec - 1 - j)];
         end
      end
      for (int j = 0; j < 32; j++) begin
         if (j < prec) begin
            result[5'((j + rotMod) % prec)] = revBits[5'(j)];
         end
      end
      return result;
   endfunction

endpackage

// File: rtl/sc_cmp_sng.sv
// Comparator-based stochastic number generator for one network variable:
// emits 1 whenever the cycle's pseudo-random code is below the probability.
module sc_cmp_sng
   import sc_ctrl_pkg::*;
#(
   parameter int PREC = 4,
   parameter int TW   = 4,
   parameter int IDX  = 0
) (
   input  logic [PREC:0]   prob_i,
   input  logic [TW-1:0]   t_i,
   output logic            bit_o
);

   logic [31:0]     tExt;
   logic [PREC-1:0] rngVal;

   // Derive this variable's code from the shared cycle counter and compare.
   // The extra MSB on the compare lets prob = 2^PREC yield a constant 1.
   always_comb begin
      tExt   = 32'(t_i);
      rngVal = PREC'(rngCode(tExt, PREC, IDX % PREC));
      bit_o  = ({1'b0, rngVal} < prob_i);
   end

endmodule

// File: rtl/sc_eval_ctrl.sv
// Sequencer for one combinational stochastic-computing AND-OR network:
// accepts a job of per-variable probabilities, streams 2^STREAM_LOG2 cycles
// of const codes and variable bits, popcounts the network outputs and
// returns the counts over a valid/ready interface.
module sc_eval_ctrl
   import sc_ctrl_pkg::*;
#(
   parameter int NUM_CONSTS  = 2,
   parameter int NUM_VARS    = 2,
   parameter int NUM_OUTPUTS = 1,
   parameter int PREC        = 4,
   parameter int STREAM_LOG2 = 4
) (
   input  logic                                  clk,
   input  logic                                  rst,
   input  logic                                  in_valid,
   output logic                                  in_ready,
   input  logic [NUM_VARS*(PREC+1)-1:0]          in_probs,
   input  logic                                  abort,
   output logic [NUM_CONSTS-1:0]                 cf_const,
   output logic [NUM_VARS-1:0]                   cf_vars,
   input  logic [NUM_OUTPUTS-1:0]                cf_outputs,
   output logic                                  out_valid,
   input  logic                                  out_ready,
   output logic [NUM_OUTPUTS*(STREAM_LOG2+1)-1:0] out_counts
);

   localparam int LOCAL_CNT_W = STREAM_LOG2 + 1;
   localparam int PROB_W      = NUM_VARS * (PREC + 1);
   localparam int COUNTS_W    = NUM_OUTPUTS * LOCAL_CNT_W;
   localparam logic [STREAM_LOG2-1:0] T_LAST = '1;

   // The const counter and the comparators both slice the cycle counter,
   // so it must be at least as wide as either of them
   if (STREAM_LOG2 < NUM_CONSTS || STREAM_LOG2 < PREC) begin : g_bad_stream
      $error("sc_eval_ctrl: STREAM_LOG2 must be >= max(NUM_CONSTS, PREC)");
   end

   state_e                  state_q, state_d;
   logic [STREAM_LOG2-1:0]  t_q, t_d;
   logic [PROB_W-1:0]       probs_q, probs_d;
   logic [COUNTS_W-1:0]     counts_q, counts_d;
   logic [NUM_VARS-1:0]     sngBits;
   logic                    running;

   // One comparator SNG per network variable, all sharing the cycle counter
   for (genvar i = 0; i < NUM_VARS; i++) begin : g_sng
      sc_cmp_sng #(
         .PREC (PREC),
         .TW   (STREAM_LOG2),
         .IDX  (i)
      ) u_sng (
         .prob_i (probs_q[i*(PREC+1) +: (PREC+1)]),
         .t_i    (t_q),
         .bit_o  (sngBits[i])
      );
   end

   // State, counter, probability and count registers; reset drops any job
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= IDLE;
         t_q      <= '0;
         probs_q  <= '0;
         counts_q <= '0;
      end else begin
         state_q  <= state_d;
         t_q      <= t_d;
         probs_q  <= probs_d;
         counts_q <= counts_d;
      end
   end

   // Next-state logic: accept in IDLE, accumulate in RUN, hold in DONE
   always_comb begin
      state_d   = state_q;
      t_d       = t_q;
      probs_d   = probs_q;
      counts_d  = counts_q;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      running   = 1'b0;
      case (state_q)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               probs_d  = in_probs;
               counts_d = '0;
               t_d      = '0;
               state_d  = RUN;
            end
         end
         RUN: begin
            running = 1'b1;
            if (abort) begin
               counts_d = '0;
               t_d      = '0;
               state_d  = IDLE;
            end else begin
               for (int k = 0; k < NUM_OUTPUTS; k++) begin
                  counts_d[k*LOCAL_CNT_W +: LOCAL_CNT_W] =
                     counts_q[k*LOCAL_CNT_W +: LOCAL_CNT_W] +
                     LOCAL_CNT_W'(cf_outputs[k]);
               end
               t_d = t_q + 1'b1;
               if (t_q == T_LAST) begin
                  state_d = DONE;
               end
            end
         end
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Network stimulus is only driven while streaming, otherwise held at zero
   always_comb begin
      cf_const   = running ? t_q[NUM_CONSTS-1:0] : '0;
      cf_vars    = running ? sngBits : '0;
      out_counts = counts_q;
   end

endmodule
